// File: rtl/fwd_select_ctrl.sv
// fwd_select_ctrl
// Operand forwarding and load-use hazard controller for the EX-stage input.
// A three-deep shadow pipeline (EX, MEM, WB) mirrors the destination
// information of in-flight instructions. For each source operand, the
// youngest matching producer drives the 2-bit operand mux select.
// A load whose result is needed by the instruction right behind it cannot
// be forwarded in time, so decode is held for one cycle. A saturating
// counter records how many cycles were lost to such stalls.
module fwd_select_ctrl #(
    parameter int REGW = 4,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [REGW-1:0] issue_rd,
    input  logic            issue_wr_en,
    input  logic            issue_is_load,
    input  logic [REGW-1:0] src_a,
    input  logic [REGW-1:0] src_b,
    input  logic            use_a,
    input  logic            use_b,
    input  logic            flush,
    output logic [1:0]      sel_a,
    output logic [1:0]      sel_b,
    output logic            stall,
    output logic [CNTW-1:0] stall_count
);

    // Destination information carried alongside each in-flight instruction.
    typedef struct packed {
        logic            valid;
        logic            wr_en;
        logic [REGW-1:0] rd;
        logic            is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{
        valid:   1'b0,
        wr_en:   1'b0,
        rd:      {REGW{1'b0}},
        is_load: 1'b0
    };

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    slot_t           ex_r;
    slot_t           mem_r;
    slot_t           wb_r;
    logic [CNTW-1:0] stall_count_r;
    logic            hazard_a_s;
    logic            hazard_b_s;
    slot_t           issue_slot_s;

    // Register 0 is hardwired to zero, so it never has a producer.
    function automatic logic is_producer(input slot_t s, input logic [REGW-1:0] r);
        return s.valid & s.wr_en & (s.rd == r) & (r != {REGW{1'b0}});
    endfunction

    // Youngest producer wins: EX, then MEM, then WB, otherwise the regfile.
    function automatic logic [1:0] pick_sel(
        input logic            use_op,
        input logic [REGW-1:0] src,
        input slot_t           ex_s,
        input slot_t           mem_s,
        input slot_t           wb_s
    );
        logic [1:0] sel_v;
        if (!use_op || (src == {REGW{1'b0}})) begin
            sel_v = SEL_RF;
        end else if (is_producer(ex_s, src)) begin
            sel_v = SEL_EX;
        end else if (is_producer(mem_s, src)) begin
            sel_v = SEL_MEM;
        end else if (is_producer(wb_s, src)) begin
            sel_v = SEL_WB;
        end else begin
            sel_v = SEL_RF;
        end
        return sel_v;
    endfunction

    // Detect load-use hazards and compute operand selects and the stall request.
    always_comb begin
        hazard_a_s = 1'b0;
        hazard_b_s = 1'b0;
        sel_a      = SEL_RF;
        sel_b      = SEL_RF;
        stall      = 1'b0;

        hazard_a_s = use_a & is_producer(ex_r, src_a) & ex_r.is_load;
        hazard_b_s = use_b & is_producer(ex_r, src_b) & ex_r.is_load;

        // A load in EX has no result yet; the operand waits on the regfile path.
        if (hazard_a_s) begin
            sel_a = SEL_RF;
        end else begin
            sel_a = pick_sel(use_a, src_a, ex_r, mem_r, wb_r);
        end

        if (hazard_b_s) begin
            sel_b = SEL_RF;
        end else begin
            sel_b = pick_sel(use_b, src_b, ex_r, mem_r, wb_r);
        end

        // A flushed instruction is discarded anyway, so it never needs to wait.
        stall = issue_valid & (hazard_a_s | hazard_b_s) & ~flush;
    end

    // Build the slot entering EX; stalled or flushed issues become bubbles.
    always_comb begin
        issue_slot_s = SLOT_EMPTY;
        if (issue_valid && !stall && !flush) begin
            issue_slot_s.valid   = 1'b1;
            issue_slot_s.wr_en   = issue_wr_en;
            issue_slot_s.rd      = issue_rd;
            issue_slot_s.is_load = issue_is_load;
        end else begin
            issue_slot_s = SLOT_EMPTY;
        end
    end

    // Advance the shadow pipeline one stage per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_r  <= SLOT_EMPTY;
            mem_r <= SLOT_EMPTY;
            wb_r  <= SLOT_EMPTY;
        end else begin
            wb_r  <= mem_r;
            mem_r <= ex_r;
            ex_r  <= issue_slot_s;
        end
    end

    // Count stall cycles, holding at the maximum value instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_r <= {CNTW{1'b0}};
        end else if (stall && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_ONE;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// tb_fwd_select_ctrl
// Directed bench for fwd_select_ctrl. Two instances share all inputs: one
// with the default 16-bit stall counter and one with a 2-bit counter so that
// saturation is reachable in a handful of stalls.
module tb_fwd_select_ctrl;

    localparam int REGW = 4;

    logic            clk_s;
    logic            reset_s;
    logic            issue_valid_s;
    logic [REGW-1:0] issue_rd_s;
    logic            issue_wr_en_s;
    logic            issue_is_load_s;
    logic [REGW-1:0] src_a_s;
    logic [REGW-1:0] src_b_s;
    logic            use_a_s;
    logic            use_b_s;
    logic            flush_s;
    logic [1:0]      sel_a_s;
    logic [1:0]      sel_b_s;
    logic            stall_s;
    logic [15:0]     stall_count_s;
    logic [1:0]      sm_sel_a_s;
    logic [1:0]      sm_sel_b_s;
    logic            sm_stall_s;
    logic [1:0]      sm_stall_count_s;

    int checks_r;
    int failures_r;
    int exp_stalls_r;

    fwd_select_ctrl #(.REGW(REGW), .CNTW(16)) dut (
        .clk           (clk_s),
        .reset         (reset_s),
        .issue_valid   (issue_valid_s),
        .issue_rd      (issue_rd_s),
        .issue_wr_en   (issue_wr_en_s),
        .issue_is_load (issue_is_load_s),
        .src_a         (src_a_s),
        .src_b         (src_b_s),
        .use_a         (use_a_s),
        .use_b         (use_b_s),
        .flush         (flush_s),
        .sel_a         (sel_a_s),
        .sel_b         (sel_b_s),
        .stall         (stall_s),
        .stall_count   (stall_count_s)
    );

    fwd_select_ctrl #(.REGW(REGW), .CNTW(2)) dut_small (
        .clk           (clk_s),
        .reset         (reset_s),
        .issue_valid   (issue_valid_s),
        .issue_rd      (issue_rd_s),
        .issue_wr_en   (issue_wr_en_s),
        .issue_is_load (issue_is_load_s),
        .src_a         (src_a_s),
        .src_b         (src_b_s),
        .use_a         (use_a_s),
        .use_b         (use_b_s),
        .flush         (flush_s),
        .sel_a         (sm_sel_a_s),
        .sel_b         (sm_sel_b_s),
        .stall         (sm_stall_s),
        .stall_count   (sm_stall_count_s)
    );

    // Free-running 10-unit clock.
    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (got !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one instruction, then let the combinational outputs settle.
    task automatic present(
        input logic            iv,
        input logic [REGW-1:0] rd,
        input logic            wr,
        input logic            ld,
        input logic [REGW-1:0] sa,
        input logic [REGW-1:0] sb,
        input logic            ua,
        input logic            ub,
        input logic            fl
    );
        issue_valid_s   = iv;
        issue_rd_s      = rd;
        issue_wr_en_s   = wr;
        issue_is_load_s = ld;
        src_a_s         = sa;
        src_b_s         = sb;
        use_a_s         = ua;
        use_b_s         = ub;
        flush_s         = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk_s);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_cnt16"}, {16'd0, stall_count_s}, exp_stalls_r);
        check_eq({tag, "_cnt2"}, {30'd0, sm_stall_count_s},
                 (exp_stalls_r > 3) ? 32'd3 : exp_stalls_r);
    endtask

    initial begin
        checks_r     = 0;
        failures_r   = 0;
        exp_stalls_r = 0;

        // Reset held two cycles while decode offers a write to r5.
        reset_s = 1'b1;
        present(1'b1, 4'd5, 1'b1, 1'b0, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0);
        step();
        step();
        reset_s = 1'b0;
        present(1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0);
        check_eq("rst_sel_a", {30'd0, sel_a_s}, 32'd0);
        check_eq("rst_sel_b", {30'd0, sel_b_s}, 32'd0);
        check_eq("rst_stall", {31'd0, stall_s}, 32'd0);
        check_counters("rst");

        // Back-to-back writes of r3, r4, r5.
        present(1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        present(1'b1, 4'd4, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        present(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        // EX=r5 MEM=r4 WB=r3
        present(1'b1, 4'd0, 1'b0, 1'b0, 4'd3, 4'd5, 1'b1, 1'b1, 1'b0);
        check_eq("fwd_wb_a", {30'd0, sel_a_s}, 32'd3);
        check_eq("fwd_ex_b", {30'd0, sel_b_s}, 32'd1);
        check_eq("fwd_stall", {31'd0, stall_s}, 32'd0);
        step();
        // EX=non-writer MEM=r5 WB=r4
        present(1'b1, 4'd0, 1'b0, 1'b0, 4'd4, 4'd5, 1'b1, 1'b1, 1'b0);
        check_eq("fwd_shift_a", {30'd0, sel_a_s}, 32'd3);
        check_eq("fwd_mem_b", {30'd0, sel_b_s}, 32'd2);
        step();
        // WB=r5, r3 has retired
        present(1'b1, 4'd0, 1'b0, 1'b0, 4'd5, 4'd3, 1'b1, 1'b1, 1'b0);
        check_eq("fwd_wb5_a", {30'd0, sel_a_s}, 32'd3);
        check_eq("fwd_gone_b", {30'd0, sel_b_s}, 32'd0);
        step();

        // Priority: two writes to r7, EX beats MEM.
        present(1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        present(1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        present(1'b1, 4'd0, 1'b1, 1'b0, 4'd7, 4'd7, 1'b1, 1'b1, 1'b0);
        check_eq("prio_ex_a", {30'd0, sel_a_s}, 32'd1);
        check_eq("prio_ex_b", {30'd0, sel_b_s}, 32'd1);
        step();
        // EX holds a write to r0, MEM=r7 (younger), WB=r7
        present(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 4'd7, 1'b1, 1'b1, 1'b0);
        check_eq("prio_r0_a", {30'd0, sel_a_s}, 32'd0);
        check_eq("prio_mem_b", {30'd0, sel_b_s}, 32'd2);
        step();

        // Drain the pipeline.
        present(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();

        // Load-use on operand B.
        present(1'b1, 4'd2, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        present(1'b1, 4'd6, 1'b1, 1'b0, 4'd9, 4'd2, 1'b1, 1'b1, 1'b0);
        check_eq("lu_stall", {31'd0, stall_s}, 32'd1);
        check_eq("lu_sel_b", {30'd0, sel_b_s}, 32'd0);
        check_eq("lu_sel_a", {30'd0, sel_a_s}, 32'd0);
        check_counters("lu_pre");
        step();
        exp_stalls_r = exp_stalls_r + 1;
        check_eq("lu_res_stall", {31'd0, stall_s}, 32'd0);
        check_eq("lu_res_sel_b", {30'd0, sel_b_s}, 32'd2);
        check_counters("lu_res");
        step();

        // Drain, then flush coinciding with a load-use hazard.
        present(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        present(1'b1, 4'd2, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        present(1'b1, 4'd6, 1'b1, 1'b0, 4'd2, 4'd0, 1'b1, 1'b0, 1'b1);
        check_eq("fl_stall", {31'd0, stall_s}, 32'd0);
        check_eq("fl_sel_a", {30'd0, sel_a_s}, 32'd0);
        step();
        // EX must be a bubble (r6 dropped), MEM holds the load
        present(1'b1, 4'd0, 1'b0, 1'b0, 4'd2, 4'd6, 1'b1, 1'b1, 1'b0);
        check_eq("fl_mem_a", {30'd0, sel_a_s}, 32'd2);
        check_eq("fl_bubble_b", {30'd0, sel_b_s}, 32'd0);
        check_eq("fl_next_stall", {31'd0, stall_s}, 32'd0);
        check_counters("fl");
        step();

        // Five stalls with both operands waiting on the same load.
        for (int i = 0; i < 5; i++) begin
            present(1'b1, 4'd2, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
            step();
            present(1'b1, 4'd0, 1'b0, 1'b0, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0);
            check_eq("sat_stall", {31'd0, stall_s}, 32'd1);
            check_eq("sat_sel_ab", {28'd0, sel_a_s, sel_b_s}, 32'd0);
            step();
            exp_stalls_r = exp_stalls_r + 1;
            check_eq("sat_res_sel_ab", {28'd0, sel_a_s, sel_b_s}, 32'ha);
            check_eq("sat_res_stall", {31'd0, stall_s}, 32'd0);
            check_counters("sat");
            step();
        end
        check_eq("sat_final_cnt2", {30'd0, sm_stall_count_s}, 32'd3);
        check_eq("sat_final_cnt16", {16'd0, stall_count_s}, 32'd6);

        // Reset asserted while a load-use stall is active.
        present(1'b1, 4'd2, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        present(1'b1, 4'd0, 1'b0, 1'b0, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0);
        check_eq("mrst_pre_stall", {31'd0, stall_s}, 32'd1);
        reset_s = 1'b1;
        step();
        reset_s = 1'b0;
        #1;
        exp_stalls_r = 0;
        check_eq("mrst_stall", {31'd0, stall_s}, 32'd0);
        check_eq("mrst_sel_ab", {28'd0, sel_a_s, sel_b_s}, 32'd0);
        check_counters("mrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule

// File: doc/fwd_select_ctrl.md
Name: fwd_select_ctrl

Overview:
- Forwarding and hazard controller that generates the 2-bit selectors for the two 4-input operand multiplexers at the EX-stage input.
- Tracks the destination registers of in-flight instructions in the EX, MEM and WB slots using an internal shadow pipeline.
- Chooses the youngest producer for each source operand.
- Raises a load-use stall when forwarding cannot resolve a dependence, and keeps a saturating stall counter for performance debug.

Parameters:
REGW, 4, register index width (2^REGW architectural registers; register 0 is hardwired zero)
CNTW, 16, width of stall cycle counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
issue_valid  input  1  decode stage presents a valid instruction this cycle
issue_rd  input  REGW  destination register of issuing instruction
issue_wr_en  input  1  issuing instruction writes issue_rd
issue_is_load  input  1  issuing instruction is a load (result available only at MEM output)
src_a  input  REGW  source register for operand A of issuing instruction
src_b  input  REGW  source register for operand B of issuing instruction
use_a  input  1  operand A is read from the register file
use_b  input  1  operand B is read from the register file
flush  input  1  kill the issuing instruction (branch redirect resolved in EX)
sel_a  output  2  operand A mux select: 00 regfile, 01 EX result, 10 MEM result, 11 WB result
sel_b  output  2  operand B mux select, same encoding
stall  output  1  hold decode; insert bubble into EX
stall_count  output  CNTW  saturating count of cycles with stall=1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset state: EX/MEM/WB slots invalid; stall_count=0. With all slots invalid, sel_a=sel_b=00 and stall=0.
- Slot contents: each slot holds {valid, wr_en, rd, is_load}.
- A slot is a "producer for r" when: valid & wr_en & rd==r & r!=0.
- sel_a (sel_b likewise) is combinational from the current slots, src_a and use_a:
  - use_a=0 or src_a=0 -> 00.
  - else EX producer -> 01; else MEM producer -> 10; else WB producer -> 11; else 00.
  - Priority is strictly EX > MEM > WB (youngest wins).
- Load-use hazard: hazard = (use_a & EX producer for src_a & EX.is_load) | (same for B).
  - While hazard=1, the affected operand's select is 00.
- stall = issue_valid & hazard & !flush. Combinational, zero latency.
- Slot update each rising edge when reset=0:
  - WB<=MEM; MEM<=EX.
  - EX<=issue fields, with valid=issue_valid & !stall & !flush.
  - Otherwise EX<=bubble (valid=0).
- Stall resolution: after one stall cycle the load moves to MEM. The held instruction then sees sel=10, and stall deasserts. A load-use stall is therefore exactly 1 cycle.
- flush and stall together: flush wins; stall=0 and EX receives a bubble. Older slots advance normally.
- stall_count: increments by 1 on every edge where stall=1. It holds at 2^CNTW-1 (no wrap). Cleared only by reset.
- Reset mid-operation: reset has priority over every other input. At the next edge all slots are invalidated and the counter is cleared, regardless of stall or flush.
- Both operands may select different stages in the same cycle. Both may stall on the same load.

Test Plan:
- Reset: assert reset 2 cycles with issue_valid=1, rd=5 -> sel_a=sel_b=00, stall=0, stall_count=0 after release.
- EX/MEM/WB forwarding: issue r3<-, r4<-, r5<- (non-load) back-to-back. Then issue src_a=3, src_b=5 -> sel_a=11, sel_b=01. Next instr src_a=4 -> sel_a=11 (after shift).
- Priority: two consecutive writes to r7, then read r7 -> sel=01 (EX beats MEM). Read of r0 with a producer of r0 present -> sel=00.
- Load-use: load r2, then src_b=2 -> stall=1 one cycle, sel_b=00. Next cycle stall=0, sel_b=10, stall_count=1.
- Flush during hazard: load r2, then src_a=2 with flush=1 -> stall=0. Following cycle: EX invalid, MEM holds the load.
- Counter saturation with CNTW=2: force 5 load-use stalls -> stall_count sticks at 3. Then reset -> 0.
